// File: rtl/gd_sequencer_if.sv
// gd_sequencer_if: bundles the run-control, gradient-handshake and result signals of
// gd_sequencer.
//   start_op / initial_x_in          : run request and starting x (Q16.16)
//   grad_req / grad_x                : gradient request and x to evaluate
//   grad_ack / grad_in               : gradient valid and returned gradient (Q16.16)
//   x_at_min / iter_used             : final x and update count of the last run
//   converged / timeout_err          : termination cause of the last run
//   done_op / busy                   : run status
// The master modport is the sequencer, which masters the gradient request.
// The slave modport is the surrounding logic, which serves gradients and starts runs.
interface gd_sequencer_if #(
  parameter int unsigned NUM_ITERATIONS = 16
) ();
  localparam int unsigned IterW = $clog2(NUM_ITERATIONS + 1);

  logic             start_op;
  logic [31:0]      initial_x_in;
  logic             grad_req;
  logic [31:0]      grad_x;
  logic             grad_ack;
  logic [31:0]      grad_in;
  logic [31:0]      x_at_min;
  logic [IterW-1:0] iter_used;
  logic             converged;
  logic             timeout_err;
  logic             done_op;
  logic             busy;

  modport master (
    input  start_op, initial_x_in, grad_ack, grad_in,
    output grad_req, grad_x, x_at_min, iter_used, converged, timeout_err, done_op, busy
  );

  modport slave (
    output start_op, initial_x_in, grad_ack, grad_in,
    input  grad_req, grad_x, x_at_min, iter_used, converged, timeout_err, done_op, busy
  );
endinterface

// File: rtl/gd_sequencer.sv
// gd_sequencer: iteration controller for a Q16.16 gradient-descent run.
// A run requests gradients over a req/ack handshake and forms each step as
// sat32((grad * LEARNING_RATE) >>> 16). It updates x <- sat32(x - step) and stops on
// |step| <= TOLERANCE, on NUM_ITERATIONS updates, or on GRAD_TIMEOUT unacknowledged
// request cycles.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : gd_sequencer_if master (start/result/gradient handshake signals)
module gd_sequencer #(
  parameter int unsigned NUM_ITERATIONS = 16,
  parameter logic [31:0] LEARNING_RATE  = 32'h0000_8000,
  parameter logic [31:0] TOLERANCE      = 32'h0000_0100,
  parameter int unsigned GRAD_TIMEOUT   = 64
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  gd_sequencer_if.master io_bus
);
  localparam int unsigned IterW = $clog2(NUM_ITERATIONS + 1);
  localparam int unsigned TmoW  = $clog2(GRAD_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StUpdate, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_x, w_x_nxt;
  logic [31:0]      r_grad, w_grad_nxt;
  logic [IterW-1:0] r_iter, w_iter_nxt;
  logic [TmoW-1:0]  r_tmo, w_tmo_nxt;
  logic [31:0]      r_x_at_min, w_x_at_min_nxt;
  logic [IterW-1:0] r_iter_used, w_iter_used_nxt;
  logic             r_converged, w_converged_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;

  // Step datapath
  logic signed [63:0] w_grad_ext, w_lr_ext, w_prod, w_prod_sh;
  logic [31:0]        w_step, w_step_abs, w_x_upd;
  logic [32:0]        w_diff;
  logic [IterW-1:0]   w_iter_inc;
  logic               w_small;

  assign w_grad_ext = {{32{r_grad[31]}}, r_grad};
  assign w_lr_ext   = {{32{LEARNING_RATE[31]}}, LEARNING_RATE};
  assign w_prod     = w_grad_ext * w_lr_ext;
  assign w_prod_sh  = w_prod >>> 16;

  // The shifted product fits in 32 bits only if bits 63..31 are all sign copies.
  assign w_step = ((w_prod_sh[63:31] == '0) || (w_prod_sh[63:31] == '1)) ? w_prod_sh[31:0] :
                  (w_prod_sh[63] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  assign w_diff  = {r_x[31], r_x} - {w_step[31], w_step};
  assign w_x_upd = (w_diff[32] == w_diff[31]) ? w_diff[31:0] :
                   (w_diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  // Most-negative step has no positive twin; treat its magnitude as the max positive.
  assign w_step_abs = !w_step[31]                ? w_step :
                      (w_step == 32'h8000_0000)  ? 32'h7FFF_FFFF : -w_step;
  assign w_small    = (w_step_abs <= TOLERANCE);
  assign w_iter_inc = r_iter + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_x           <= '0;
      r_grad        <= '0;
      r_iter        <= '0;
      r_tmo         <= '0;
      r_x_at_min    <= '0;
      r_iter_used   <= '0;
      r_converged   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_x           <= w_x_nxt;
      r_grad        <= w_grad_nxt;
      r_iter        <= w_iter_nxt;
      r_tmo         <= w_tmo_nxt;
      r_x_at_min    <= w_x_at_min_nxt;
      r_iter_used   <= w_iter_used_nxt;
      r_converged   <= w_converged_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_grad_nxt        = r_grad;
    w_iter_nxt        = r_iter;
    w_tmo_nxt         = r_tmo;
    w_x_at_min_nxt    = r_x_at_min;
    w_iter_used_nxt   = r_iter_used;
    w_converged_nxt   = r_converged;
    w_timeout_err_nxt = r_timeout_err;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start_op) begin
          w_x_nxt           = io_bus.initial_x_in;
          w_iter_nxt        = '0;
          w_tmo_nxt         = '0;
          w_converged_nxt   = 1'b0;
          w_timeout_err_nxt = 1'b0;
          w_state_nxt       = StReq;
        end
      end
      StReq: begin
        if (io_bus.grad_ack) begin
          w_grad_nxt  = io_bus.grad_in;
          w_state_nxt = StUpdate;
        end else if (r_tmo == TmoW'(GRAD_TIMEOUT - 1)) begin
          // This is the GRAD_TIMEOUT-th unacknowledged request cycle.
          w_timeout_err_nxt = 1'b1;
          w_x_at_min_nxt    = r_x;
          w_iter_used_nxt   = r_iter;
          w_state_nxt       = StDone;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      StUpdate: begin
        w_x_nxt    = w_x_upd;
        w_iter_nxt = w_iter_inc;
        w_tmo_nxt  = '0;
        if (w_small || (w_iter_inc == IterW'(NUM_ITERATIONS))) begin
          w_converged_nxt = w_small;
          w_x_at_min_nxt  = w_x_upd;
          w_iter_used_nxt = w_iter_inc;
          w_state_nxt     = StDone;
        end else begin
          w_state_nxt = StReq;
        end
      end
      StDone: begin
        // Wait for start_op to drop so one start level yields one run.
        if (!io_bus.start_op) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign io_bus.grad_req    = (r_state == StReq);
  assign io_bus.grad_x      = r_x;
  assign io_bus.x_at_min    = r_x_at_min;
  assign io_bus.iter_used   = r_iter_used;
  assign io_bus.converged   = r_converged;
  assign io_bus.timeout_err = r_timeout_err;
  assign io_bus.done_op     = (r_state == StDone);
  assign io_bus.busy        = (r_state == StReq) || (r_state == StUpdate);
endmodule

// File: tb/tb_gd_sequencer.sv
// tb_gd_sequencer: self-checking bench for gd_sequencer. Four instances cover the
// parameter sets of interest. Each has a gradient responder with 2(x-c), saturated
// constant or never-ack behaviour. Results are compared against a plain-arithmetic model.
module tb_gd_sequencer;
  localparam int NDUT = 4;
  localparam logic [31:0] LR_TAB [NDUT] = '{32'h0000_8000, 32'h0000_4000, 32'h0000_4000,
                                            32'h0002_0000};
  localparam int unsigned NI_TAB [NDUT] = '{16, 16, 4, 2};
  localparam logic [31:0] TOL = 32'h0000_0100;
  localparam int MD_LIN = 0, MD_MAX = 1, MD_NOACK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus/config (written only by the main process)
  logic        start [NDUT];
  logic [31:0] x0    [NDUT];
  int          lat   [NDUT];   // negative: random latency 0..5 per request
  int          mode  [NDUT];
  logic [31:0] cvec  [NDUT];

  // Observed outputs
  logic        req  [NDUT];
  logic [31:0] gx   [NDUT];
  logic [31:0] xmin [NDUT];
  int          iter [NDUT];
  logic        conv [NDUT];
  logic        terr [NDUT];
  logic        done [NDUT];
  logic        busy [NDUT];
  int          unstable [NDUT];

  int n_total = 0;
  int n_bad   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gd_sequencer_if #(.NUM_ITERATIONS(NI_TAB[g])) bus ();

    gd_sequencer #(
      .NUM_ITERATIONS(NI_TAB[g]),
      .LEARNING_RATE (LR_TAB[g]),
      .TOLERANCE     (TOL),
      .GRAD_TIMEOUT  (64)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (bus)
    );

    logic        ack_l = 1'b0;
    logic [31:0] gin_l = '0;
    logic [31:0] gx_hold = '0;
    logic        seen = 1'b0;
    int          wcnt = 0;
    int          cur_lat = 0;
    int          unst = 0;

    assign bus.start_op     = start[g];
    assign bus.initial_x_in = x0[g];
    assign bus.grad_ack     = ack_l;
    assign bus.grad_in      = gin_l;
    assign req[g]      = bus.grad_req;
    assign gx[g]       = bus.grad_x;
    assign xmin[g]     = bus.x_at_min;
    assign iter[g]     = 32'(bus.iter_used);
    assign conv[g]     = bus.converged;
    assign terr[g]     = bus.timeout_err;
    assign done[g]     = bus.done_op;
    assign busy[g]     = bus.busy;
    assign unstable[g] = unst;

    // Gradient responder: acts on the falling edge, also tracks grad_x stability
    always @(negedge clk) begin
      if (bus.grad_req) begin
        if (!seen) begin
          seen    = 1'b1;
          gx_hold = bus.grad_x;
        end else if (bus.grad_x !== gx_hold) begin
          unst++;
        end
        if (mode[g] != MD_NOACK && wcnt >= cur_lat) begin
          ack_l = 1'b1;
          gin_l = (mode[g] == MD_MAX) ? 32'h7FFF_FFFF : ((bus.grad_x - cvec[g]) << 1);
        end else begin
          ack_l = 1'b0;
          wcnt++;
        end
      end else begin
        ack_l   = 1'b0;
        seen    = 1'b0;
        wcnt    = 0;
        cur_lat = (lat[g] < 0) ? int'($urandom_range(0, 5)) : lat[g];
      end
    end
  end

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: iterate the descent rules directly in 64-bit integer arithmetic.
  function automatic void model(input int i, input logic [31:0] xs, input logic [31:0] c,
                                input int md, output logic [31:0] xf, output int it,
                                output bit cv, output bit te);
    longint x, g, s, lr, hi, lo;
    logic [31:0] gw;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    lr = longint'(LR_TAB[i]);
    x  = longint'($signed(xs));
    it = 0; cv = 1'b0; te = 1'b0;
    if (md == MD_NOACK) begin
      xf = xs;
      te = 1'b1;
      return;
    end
    for (int k = 0; k < int'(NI_TAB[i]); k++) begin
      gw = (md == MD_MAX) ? 32'h7FFF_FFFF : ((32'(x) - c) << 1);
      g  = longint'($signed(gw));
      s  = (g * lr) >>> 16;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      x = x - s;
      if (x > hi) x = hi;
      if (x < lo) x = lo;
      it++;
      if (((s < 0) ? -s : s) <= longint'(TOL)) begin
        cv = 1'b1;
        break;
      end
    end
    xf = 32'(x);
  endfunction

  // Starts a run (start held high afterwards) and counts cycles until done_op.
  task automatic run(input int i, input logic [31:0] xs, input int l, input int md,
                     input logic [31:0] c, output int cyc);
    lat[i] = l; mode[i] = md; cvec[i] = c; x0[i] = xs;
    @(negedge clk);
    start[i] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done[i] && cyc < 3000);
    chk("done_reached", done[i], 1);
  endtask

  task automatic release_start(input int i);
    @(negedge clk);
    start[i] = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_release", done[i], 0);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] xs;
    int          l;
    int          md;
    logic [31:0] xe;
    int          ie;
    bit          ce;
    bit          te;
    int          cyc;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    int          cyc, it, n_req, n_nd;
    logic [31:0] xf, xs, c;
    bit          cv, te;
    int          i;

    for (int k = 0; k < NDUT; k++) begin
      start[k] = 1'b0; x0[k] = '0; lat[k] = 0; mode[k] = MD_LIN; cvec[k] = 32'h0004_0000;
    end

    vecs[0] = '{0, 32'h0,         0, MD_LIN,   32'h0004_0000, 2,  1'b1, 1'b0, 5};
    vecs[1] = '{1, 32'h0,         3, MD_LIN,   32'h0003_FF00, 10, 1'b1, 1'b0, 51};
    vecs[2] = '{2, 32'h0,         0, MD_LIN,   32'h0003_C000, 4,  1'b0, 1'b0, 9};
    vecs[3] = '{0, 32'h0001_2345, 0, MD_NOACK, 32'h0001_2345, 0,  1'b0, 1'b1, 65};
    vecs[4] = '{3, 32'h0,         0, MD_MAX,   32'h8000_0000, 2,  1'b0, 1'b0, 5};

    // Reset values
    #3;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_req", req[k], 0);   chk("rst_gx", gx[k], 0);
      chk("rst_xmin", xmin[k], 0); chk("rst_iter", iter[k], 0);
      chk("rst_conv", conv[k], 0); chk("rst_terr", terr[k], 0);
      chk("rst_done", done[k], 0); chk("rst_busy", busy[k], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int v = 0; v < 5; v++) begin
      run(vecs[v].inst, vecs[v].xs, vecs[v].l, vecs[v].md, 32'h0004_0000, cyc);
      chk("vec_xmin", xmin[vecs[v].inst], vecs[v].xe);
      chk("vec_iter", iter[vecs[v].inst], vecs[v].ie);
      chk("vec_conv", conv[vecs[v].inst], vecs[v].ce);
      chk("vec_terr", terr[vecs[v].inst], vecs[v].te);
      chk("vec_cycles", cyc, vecs[v].cyc);
      release_start(vecs[v].inst);
    end
    chk("grad_x_stable", unstable[1], 0);

    // Restart after a timeout run: flags clear at start, old x_at_min holds.
    lat[0] = 0; mode[0] = MD_LIN; cvec[0] = 32'h0004_0000; x0[0] = 32'h0000_5000;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", req[0], 1);
    chk("restart_gx", gx[0], 32'h0000_5000);
    chk("restart_busy", busy[0], 1);
    chk("restart_terr_clr", terr[0], 0);
    chk("restart_xmin_hold", xmin[0], 32'h0001_2345);
    cyc = 1;
    while (!done[0] && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    model(0, 32'h0000_5000, 32'h0004_0000, MD_LIN, xf, it, cv, te);
    chk("restart_xmin", xmin[0], xf);
    chk("restart_iter", iter[0], it);
    chk("restart_conv", conv[0], cv);

    // Start held high across DONE: no second run
    n_req = 0; n_nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (req[0]) n_req++;
      if (!done[0]) n_nd++;
    end
    chk("hold_no_rerun", n_req, 0);
    chk("hold_done_stays", n_nd, 0);
    release_start(0);

    // Reset mid-REQ: grad_req must drop without a clock edge
    lat[1] = 0; mode[1] = MD_NOACK; x0[1] = 32'h0000_7777;
    @(negedge clk);
    start[1] = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_req", req[1], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", req[1], 0);  chk("async_rst_gx", gx[1], 0);
    chk("async_rst_xmin", xmin[1], 0); chk("async_rst_iter", iter[1], 0);
    chk("async_rst_conv", conv[1], 0); chk("async_rst_terr", terr[1], 0);
    chk("async_rst_done", done[1], 0); chk("async_rst_busy", busy[1], 0);
    start[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      i  = int'($urandom_range(0, 1));
      xs = 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
      c  = 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
      run(i, xs, -1, MD_LIN, c, cyc);
      model(i, xs, c, MD_LIN, xf, it, cv, te);
      chk("rnd_xmin", xmin[i], xf);
      chk("rnd_iter", iter[i], it);
      chk("rnd_conv", conv[i], cv);
      chk("rnd_terr", terr[i], te);
      release_start(i);
    end
    chk("rnd_grad_x_stable0", unstable[0], 0);
    chk("rnd_grad_x_stable1", unstable[1], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/gd_sequencer.md
# gd_sequencer

Iteration controller for the Q16.16 gradient-descent datapath. It sequences one descent run: it issues gradient requests to the shared gradient-function unit over a req/ack handshake and forms each step as gradient × LEARNING_RATE. It then updates x with saturating arithmetic and stops on convergence, iteration cap or gradient timeout. It sits between the top-level start/done interface and the gradient unit.

## Interface
- NUM_ITERATIONS, 16, maximum update iterations per run (≥1)
- LEARNING_RATE, 32'h00008000, Q16.16 step multiplier (0.5)
- TOLERANCE, 32'h00000100, Q16.16 convergence threshold on |step| (2^-8)
- GRAD_TIMEOUT, 64, cycles grad_req may stay unacknowledged before abort
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_op  in  1  level start request
- initial_x_in  in  32  signed Q16.16 starting x, sampled at start
- grad_req  out  1  gradient request, high until acknowledged
- grad_x  out  32  signed Q16.16 x to evaluate; stable while grad_req high
- grad_ack  in  1  gradient valid; sampled only while grad_req high
- grad_in  in  32  signed Q16.16 gradient, captured on grad_req & grad_ack
- x_at_min  out  32  final x of last run
- iter_used  out  $clog2(NUM_ITERATIONS+1)  updates performed in last run
- converged  out  1  last run ended on |step| ≤ TOLERANCE
- timeout_err  out  1  last run aborted on gradient timeout
- done_op  out  1  high while in DONE
- busy  out  1  high in REQ/UPDATE

## Operation
- States: IDLE, REQ, UPDATE, DONE.
- IDLE: start_op=1 → load x←initial_x_in, clear iter count, converged, timeout_err, timeout counter; go REQ.
- REQ: grad_req=1, grad_x=x. On grad_ack=1, capture grad_in, go UPDATE. Otherwise increment timeout counter. On reaching GRAD_TIMEOUT, set timeout_err=1, x_at_min←x, go DONE.
- UPDATE, one cycle: step = sat32((grad × LEARNING_RATE) >>> 16) on a full 64-bit signed product. x ← sat32(x − step). iter += 1.
  - |step| ≤ TOLERANCE → converged=1, DONE.
  - Else if iter == NUM_ITERATIONS → DONE with converged=0.
  - Else REQ, with the timeout counter cleared.
- sat32 clamps to 0x7FFFFFFF / 0x80000000. For the |step| test, 0x80000000 is treated as 0x7FFFFFFF.
- On DONE entry: x_at_min←x, iter_used←iter.
- DONE: done_op=1. The block stays in DONE while start_op=1 and returns to IDLE only after start_op=0, so one start level produces exactly one run.
- start_op changes mid-run are ignored. grad_ack outside REQ is ignored.
- Result outputs hold until the next run's IDLE→REQ transition, which clears converged and timeout_err. x_at_min and iter_used are overwritten only at DONE entry.
- Reset, at any time including mid-run: state=IDLE; grad_req=0 immediately; grad_x=0; x_at_min=0; iter_used=0; converged=0; timeout_err=0; done_op=0; busy=0.

## Timing
- Start sampled at edge 0 → grad_req high from cycle 1.
- Ack may arrive in the first REQ cycle. Minimum iteration is 2 cycles (REQ + UPDATE), and grad_req deasserts in the cycle after the acked edge.
- done_op rises the cycle after the final UPDATE or timeout edge. Minimum run, start to done_op, is 3 cycles.
- A timeout abort occurs exactly GRAD_TIMEOUT cycles after grad_req rises with no ack.

## Test plan
- Gradient model 2(x−4), zero-latency ack, x0=0, default parameters → x_at_min=0x00040000, iter_used=2, converged=1, timeout_err=0.
- Same model, LEARNING_RATE=0x00004000, ack latency 3 cycles → x_at_min=0x0003FF00, iter_used=10, converged=1; grad_x stays stable through every wait.
- Same model, LEARNING_RATE=0x00004000, NUM_ITERATIONS=4 → x_at_min=0x0003C000, iter_used=4, converged=0.
- Ack never asserted, x0=0x00012345 → done_op at cycle 1+64, timeout_err=1, x_at_min=0x00012345, iter_used=0.
- grad_in=0x7FFFFFFF constant, LEARNING_RATE=0x00020000, NUM_ITERATIONS=2, x0=0 → step saturates to 0x7FFFFFFF; x goes 0x80000001 then 0x80000000; x_at_min=0x80000000, converged=0.
- Reset: rst_n low during REQ → grad_req drops without a clock edge, all outputs return to reset values. Hold start_op high across DONE → exactly one run. Drop start_op, re-raise it → second run with converged/timeout_err cleared at start.
